// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time program loader: the write side of the instruction store.
// Collects a byte stream over a valid/ready handshake, packs each group of
// four bytes little-endian into a 32-bit instruction word, and writes the
// words to consecutive word addresses starting at 0. The datapath is held in
// reset (cpu_hold=1) until the whole program has been written.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a 32-bit checksum word follows the program. It is compared
//   against the running sum (mod 2^32) of all written words. On a mismatch,
//   error is raised and the datapath stays held.
//   When undefined, the last write goes straight to DONE and error is tied to 0.
//
// Parameters
//   WORDS   number of instruction words per session (2..2^ADDR_W)
//   ADDR_W  width of the internal word counter
//
// Ports
//   clock       in   1   rising-edge clock
//   reset       in   1   synchronous, active-low reset
//   start       in   1   pulse; begins a load session from IDLE or DONE
//   byte_in     in   8   stream byte
//   byte_valid  in   1   byte_in is valid
//   byte_ready  out  1   loader accepts a byte this cycle (registered)
//   mem_we      out  1   instruction-memory write strobe, one cycle per word
//   mem_addr    out  32  word address, zero-extended word counter
//   mem_data    out  32  assembled instruction word
//   cpu_hold    out  1   1 = datapath held in reset
//   busy        out  1   session in progress
//   done        out  1   load complete, held until the next start
//   error       out  1   checksum mismatch
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  logic [2:0]        state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic              take;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic [23:0] chk_low;
  logic        error_q;
  logic        chk_bad;

  // The 4th checksum byte is combined with the three stored ones on the fly.
  assign chk_bad = ({byte_in, chk_low} != sum);
  assign error   = error_q;
`else
  assign error = 1'b0;
`endif

  // byte_ready is only ever high in RECV/CHECK, so a transfer implies one of
  // those states; byte_valid in any other state is simply ignored.
  assign take = byte_valid && byte_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      word_cnt   <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_data   <= 32'd0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= 32'd0;
      chk_low    <= 24'd0;
      error_q    <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        // A new session may start from IDLE or after a finished load.
        IDLE, DONE: begin
          if (start) begin
            state      <= RECV;
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 32'd0;
            error_q    <= 1'b0;
`endif
          end
        end

        // Bytes land little-endian; the 4th one launches the write cycle.
        RECV: begin
          if (take) begin
            mem_data[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= 32'(word_cnt);
            end
          end
        end

        // Single write cycle; the counter stops at the last word rather than wrapping.
        WRITE: begin
`ifdef LOADER_CHECKSUM_EN
          sum <= sum + mem_data;
`endif
          if (word_cnt == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
            state      <= CHECK;
            byte_ready <= 1'b1;
`else
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
`endif
          end else begin
            word_cnt   <= word_cnt + ADDR_W'(1);
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum word; on a mismatch the datapath is kept in reset.
        CHECK: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              error_q    <= chk_bad;
              cpu_hold   <= chk_bad;
            end else begin
              chk_low[{byte_cnt, 3'b000} +: 8] <= byte_in;
            end
          end
        end
`endif

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader (WORDS=32, ADDR_W=5). Drives the byte
// stream through the valid/ready handshake and logs every memory write.
// The logged addresses and data are compared with the image the bench
// itself expects. The LOADER_CHECKSUM_EN macro selects which end-of-session
// behaviour is expected.
// ---------------------------------------------------------------------------
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checkCount = 0;
  int failCount  = 0;
  logic [31:0] writeAddr[$];
  logic [31:0] writeData[$];

  program_loader #(.WORDS(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every write strobe mid-cycle, well away from the rising edge.
  always @(negedge clock) begin
    if (reset && mem_we) begin
      writeAddr.push_back(mem_addr);
      writeData.push_back(mem_data);
    end
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds byte_valid until the byte is taken; optional random idle gap first.
  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    bit sent;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        tick();
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    sent       = 1'b0;
    for (int i = 0; i < 50 && !sent; i++) begin
      sent = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    if (!sent) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL byte_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], gaps);
  endtask

  task automatic checkImage(input string tag);
    int bad;
    bad = 0;
    checkOutput({tag, "_count"}, 32'(writeAddr.size()), 32'd32);
    for (int i = 0; i < writeAddr.size(); i++) begin
      if (writeAddr[i] !== 32'(i) || writeData[i] !== 32'(i)) bad++;
    end
    checkOutput({tag, "_bad_words"}, 32'(bad), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset values.
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_mem_we",     32'(mem_we),     32'd0);
    checkOutput("rst_mem_addr",   mem_addr,        32'd0);
    checkOutput("rst_mem_data",   mem_data,        32'd0);
    checkOutput("rst_flags",      {28'd0, busy, done, error, cpu_hold}, 32'h1);

    // Abort mid-RECV with two bytes taken.
    pulseStart();
    checkOutput("recv_ready", {30'd0, byte_ready, busy}, 32'h3);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("abort_ctrl", {26'd0, byte_ready, mem_we, busy, done, error, cpu_hold}, 32'h1);
    checkOutput("abort_data", mem_data, 32'd0);
    reset = 1'b1;
    // In IDLE a valid byte must not be accepted.
    byte_valid = 1'b1;
    tick();
    checkOutput("idle_ignores", {30'd0, byte_ready, busy}, 32'h0);
    byte_valid = 1'b0;

    // First word: 13 00 00 00 must write 0x00000013 at address 0.
    pulseStart();
    writeAddr.delete();
    writeData.delete();
    sendWord(32'h00000013, 1'b0);
    checkOutput("w0_we",   32'(mem_we), 32'd1);
    checkOutput("w0_addr", mem_addr,    32'd0);
    checkOutput("w0_data", mem_data,    32'h00000013);
    tick();
    checkOutput("w0_we_one_cycle", 32'(mem_we), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Full load, value = address, with a start pulse ignored mid-session.
    pulseStart();
    writeAddr.delete();
    writeData.delete();
    sendWord(32'd0, 1'b0);
    sendWord(32'd1, 1'b0);
    tick();
    pulseStart();
    checkOutput("start_ignored", {30'd0, busy, done}, 32'h2);
    for (int w = 2; w < 32; w++) sendWord(32'(w), 1'b0);
    checkOutput("last_we",   {30'd0, mem_we, cpu_hold}, 32'h3);
    checkOutput("last_addr", mem_addr, 32'd31);
    tick();
`ifdef LOADER_CHECKSUM_EN
    checkOutput("check_state", {28'd0, byte_ready, cpu_hold, done, busy}, 32'hD);
    sendWord(32'h000001F0, 1'b0);
    checkOutput("sum_ok", {27'd0, byte_ready, busy, done, error, cpu_hold}, 32'h4);
`else
    checkOutput("done_flags", {27'd0, byte_ready, busy, done, error, cpu_hold}, 32'h4);
`endif
    checkOutput("addr_held", mem_addr, 32'd31);
    checkImage("load1");

    // Restart from DONE with random valid gaps; image must be rewritten from 0.
    pulseStart();
    checkOutput("restart_flags", {29'd0, busy, done, cpu_hold}, 32'h5);
    writeAddr.delete();
    writeData.delete();
    for (int w = 0; w < 32; w++) sendWord(32'(w), 1'b1);
    tick();
`ifdef LOADER_CHECKSUM_EN
    sendWord(32'h000001F1, 1'b1);
    checkOutput("sum_bad", {28'd0, busy, done, error, cpu_hold}, 32'h7);
`else
    checkOutput("done2_flags", {28'd0, busy, done, error, cpu_hold}, 32'h4);
`endif
    checkImage("load2");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
